pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_slice.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_adder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults, slice-width helper and stage payload type for pipelined_adder
package adder_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_STAGES = 4;

    function automatic int slice_w(input int w, input int stages);
        return w / stages;
    endfunction

    // Default-width stage payload; the top re-declares it at its own W.
    typedef struct packed {
        logic [DEF_W-1:0] a_hi;
        logic [DEF_W-1:0] b_hi;
        logic [DEF_W-1:0] s_lo;
        logic             c;
    } stage_t;

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational CW-bit ripple chain of full_adder cells
module adder_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          cmsb
);

    logic [CW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CW; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CW];
    // carry into the slice MSB; XOR with cout gives signed overflow on the top slice
    assign cmsb = c[CW-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep pipelined ripple-carry adder with valid/ready stream
// Optional signed-overflow output enabled by ADDER_OVF_EN.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int STAGES = DEF_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int SDIV = (STAGES < 1) ? 1 : STAGES;
    localparam int CW   = slice_w(W, SDIV);

    if (STAGES < 1 || STAGES > W || (W % SDIV) != 0) begin : g_bad_cfg
        $error("pipelined_adder: W must be a multiple of STAGES and 1 <= STAGES <= W");
    end

    typedef struct packed {
        logic [W-1:0] a_hi;
        logic [W-1:0] b_hi;
        logic [W-1:0] s_lo;
        logic         c;
    } stage_w_t;

    stage_w_t          st_q   [STAGES];
    stage_w_t          st_nxt [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_prev;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] cmsb;
    logic              unused_bits;

    // A stage may load when it is empty or when the stage after it is moving.
    always_comb begin
        en = '0;
        en[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            en[k] = !v_q[k] || en[k+1];
        end
    end

    always_comb begin
        v_prev    = '0;
        v_prev[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            v_prev[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_w_t      in_k;
        logic [CW-1:0] s_k;
        logic          c_k;

        if (k == 0) begin : g_first
            assign in_k = {a, b, {W{1'b0}}, cin};
        end else begin : g_next
            assign in_k = st_q[k-1];
        end

        adder_slice #(.CW(CW)) u_slice (
            .a    (in_k.a_hi[k*CW +: CW]),
            .b    (in_k.b_hi[k*CW +: CW]),
            .cin  (in_k.c),
            .s    (s_k),
            .cout (c_k),
            .cmsb (cmsb[k])
        );

        always_comb begin
            st_nxt[k]                  = in_k;
            st_nxt[k].s_lo[k*CW +: CW] = s_k;
            st_nxt[k].c                = c_k;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v_q[k]  <= v_prev[k];
                    st_q[k] <= st_nxt[k];
                end
            end
        end
    end

`ifdef ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en[STAGES-1]) begin
            ovf_q <= cmsb[STAGES-1] ^ st_nxt[STAGES-1].c;
        end
    end

    assign ovf = ovf_q;
`endif

    // The last stage never forwards operands, and only the top slice's cmsb matters.
    assign unused_bits = ^{st_q[STAGES-1].a_hi, st_q[STAGES-1].b_hi, cmsb};

    assign in_ready  = en[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = st_q[STAGES-1].s_lo;
    assign cout      = st_q[STAGES-1].c;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed self-checking bench for pipelined_adder (W=8, STAGES=2)
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
`ifdef ADDER_OVF_EN
    logic         ovf;
`endif

    pipelined_adder #(.W(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_pop  = 0;
    int          n_push = 0;
    int          n_stall = 0;
    logic        acc;
    logic        rdy_seen;
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {8'b0, ci};
        o = (x[7] == y[7]) && (t[7] != x[7]);
`ifdef ADDER_OVF_EN
        return {6'b0, o, t};
`else
        return {7'b0, t} | {15'b0, o & 1'b0};
`endif
    endfunction

    function automatic logic [15:0] obs_res();
`ifdef ADDER_OVF_EN
        return {6'b0, ovf, cout, sum};
`else
        return {7'b0, cout, sum};
`endif
    endfunction

    // One clock: evaluate the handshake at the negedge, then step to just after the posedge.
    task automatic cycle();
        logic [15:0] e;
        @(negedge clk);
        acc      = in_valid && in_ready;
        rdy_seen = in_ready;
        if (out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                chk("spurious_out", 16'h1, 16'h0);
            end else begin
                e = sb.pop_front();
                chk("result", obs_res(), e);
            end
        end
        if (acc) begin
            sb.push_back(model(a, b, cin));
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic ci, input logic [15:0] exp);
        a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, {15'b0, in_ready}, 16'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < S - 1; i++) begin
            @(negedge clk);
            chk({tag, "_early"}, {15'b0, out_valid}, 16'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({tag, "_valid"}, {15'b0, out_valid}, 16'h1);
        chk(tag, obs_res(), exp);
        @(posedge clk); #1;
    endtask

    logic [7:0] va [4] = '{8'h10, 8'hFF, 8'h80, 8'h01};
    logic [7:0] vb [4] = '{8'h20, 8'hFF, 8'h80, 8'h02};
    logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int acc_n;
        int p0;
        int cyc;

        // reset state
        #2;
        chk("rst_out_valid", {15'b0, out_valid}, 16'h0);
        chk("rst_sum", {8'b0, sum}, 16'h0);
        chk("rst_cout", {15'b0, cout}, 16'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {15'b0, in_ready}, 16'h1);
        @(posedge clk); #1;

        // basic directed adds, including wrap-around via cin
        send_one("ff_01", 8'hFF, 8'h01, 1'b0, 16'h100);
        send_one("0f_01", 8'h0F, 8'h01, 1'b0, 16'h010);
        send_one("ff_00_c", 8'hFF, 8'h00, 1'b1, 16'h100);

        // streaming back-to-back with out_ready held high
        out_ready = 1'b1;
        p0 = n_pop;
        n_stall = 0;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            in_valid = 1'b1;
            cycle();
            if (!rdy_seen) n_stall++;
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        @(negedge clk);
        chk("stream_in_ready", n_stall[15:0], 16'h0);
        chk("stream_drained_valid", {15'b0, out_valid}, 16'h0);
        chk("stream_count", 16'(n_pop - p0), 16'd200);
        chk("stream_sb_empty", 16'(sb.size()), 16'h0);
        @(posedge clk); #1;

        // backpressure: stall with 4 pairs offered
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            a = va[acc_n]; b = vb[acc_n]; cin = vc[acc_n]; in_valid = 1'b1;
            cycle();
            if (acc) acc_n++;
        end
        chk("bp_accepts", 16'(acc_n), 16'd2);
        chk("bp_in_ready_low", {15'b0, in_ready}, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_valid", {15'b0, out_valid}, 16'h1);
            chk("bp_hold_sum", obs_res(), 16'h030);
        end
        out_ready = 1'b1;
        p0 = n_pop;
        cyc = 0;
        while ((acc_n < 4 || sb.size() != 0) && cyc < 40) begin
            if (acc_n < 4) begin
                a = va[acc_n]; b = vb[acc_n]; cin = vc[acc_n]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (acc) acc_n++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_released_count", 16'(n_pop - p0), 16'd4);

        // random out_ready, 40 pairs
        p0 = n_pop;
        acc_n = 0;
        cyc = 0;
        while ((acc_n < 40 || sb.size() != 0) && cyc < 400) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            in_valid = (acc_n < 40);
            out_ready = 1'($urandom);
            cycle();
            if (acc) acc_n++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_bp_count", 16'(n_pop - p0), 16'd40);
        chk("rand_bp_sb_empty", 16'(sb.size()), 16'h0);

        // reset with two results in flight
        out_ready = 1'b0;
        a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
        cycle();
        a = 8'h33; b = 8'h44;
        cycle();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {15'b0, out_valid}, 16'h0);
        chk("midrst_sum", {8'b0, sum}, 16'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("postrst_idle", {15'b0, out_valid}, 16'h0);
        end
        send_one("postrst", 8'h3C, 8'h05, 1'b1, 16'h042);

`ifdef ADDER_OVF_EN
        send_one("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 16'h280);
        send_one("ovf_80_ff", 8'h80, 8'hFF, 1'b0, 16'h37F);
        send_one("ovf_05_fb", 8'h05, 8'hFB, 1'b0, 16'h100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
